// File: rtl/join_note_octave_pkg.sv
// ---------------------------------------------------------------------------
// join_note_octave_pkg
//
// Shared note package used by the octave/note split and join logic.
//
// Contents:
//   NOTES_PER_OCT  - semitones per octave (12)
//   MAX_OCT        - highest octave number (7)
//   MAX_NOTE       - highest legal note within an octave (11)
//   ST_*           - FSM state encoding of the octave/note join sequencer
//   state_name()   - readable state name for debug printing in benches
// ---------------------------------------------------------------------------
package join_note_octave_pkg;

  localparam int NOTES_PER_OCT = 12;
  localparam int MAX_OCT       = 7;
  localparam int MAX_NOTE      = NOTES_PER_OCT - 1;

  // Join sequencer states. Plain constants keep the encoding visible on
  // the debug port and usable from older tools.
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_ADD8 = 3'd1;
  localparam logic [2:0] ST_ADD4 = 3'd2;
  localparam logic [2:0] ST_ADDN = 3'd3;
  localparam logic [2:0] ST_HOLD = 3'd4;

  function automatic string state_name(input logic [2:0] st);
    case (st)
      ST_IDLE: return "IDLE";
      ST_ADD8: return "ADD8";
      ST_ADD4: return "ADD4";
      ST_ADDN: return "ADDN";
      ST_HOLD: return "HOLD";
      default: return "????";
    endcase
  endfunction

endpackage

// File: rtl/join_note_octave.sv
// ---------------------------------------------------------------------------
// join_note_octave
//
// Composes a flat note index from an octave/note pair:
//   index = octave*12 + note
// The multiply is done as three sequential adds (octave<<3, octave<<2,
// note) into an 8-bit accumulator, driven by a small FSM.
//
// Ports:
//   clk        in   clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   in_octave  in   [2:0] octave 0..7
//   in_note    in   [3:0] note within octave, 0..11 legal
//   in_valid   in   request present
//   in_ready   out  block can accept a request (IDLE only)
//   out_index  out  [OUT_W-1:0] composed index, saturates at MAX_IDX
//   out_err    out  note illegal or index saturated
//   out_valid  out  out_index/out_err valid (HOLD only)
//   out_ready  in   consumer takes the result
//   dbg_state  out  [2:0] current FSM state for checkers/waveforms
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. The input side is ready only in IDLE; the output side holds
// valid with stable data in HOLD until out_ready is seen, then returns to
// IDLE, so the next request is taken no earlier than the following cycle.
// ---------------------------------------------------------------------------
module join_note_octave
  import join_note_octave_pkg::*;
#(
  parameter int OUT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       in_octave,
  input  logic [3:0]       in_note,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [OUT_W-1:0] out_index,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       dbg_state
);

  localparam logic [31:0] MAX_IDX = (32'd1 << OUT_W) - 32'd1;

  logic [2:0]       state_q,     state_d;
  logic [7:0]       acc_q,       acc_d;
  logic [2:0]       oct_q,       oct_d;
  logic [3:0]       note_q,      note_d;
  logic [OUT_W-1:0] out_index_q, out_index_d;
  logic             out_err_q,   out_err_d;
  logic             out_valid_q, out_valid_d;

  logic [7:0]       sum;

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    oct_d       = oct_q;
    note_d      = note_q;
    out_index_d = out_index_q;
    out_err_d   = out_err_q;
    out_valid_d = out_valid_q;
    // Final sum of the ADDN step; 7*12+15 = 99 fits in 8 bits.
    sum         = acc_q + {4'd0, note_q};

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          oct_d   = in_octave;
          note_d  = in_note;
          acc_d   = 8'd0;
          state_d = ST_ADD8;
        end
      end
      ST_ADD8: begin
        acc_d   = acc_q + {2'd0, oct_q, 3'd0};
        state_d = ST_ADD4;
      end
      ST_ADD4: begin
        acc_d   = acc_q + {3'd0, oct_q, 2'd0};
        state_d = ST_ADDN;
      end
      ST_ADDN: begin
        acc_d = sum;
        if ((note_q > 4'(MAX_NOTE)) || ({24'd0, sum} > MAX_IDX)) begin
          out_err_d   = 1'b1;
          out_index_d = OUT_W'(MAX_IDX);
        end else begin
          out_err_d   = 1'b0;
          out_index_d = OUT_W'(sum);
        end
        out_valid_d = 1'b1;
        state_d     = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= 8'd0;
      oct_q       <= 3'd0;
      note_q      <= 4'd0;
      out_index_q <= '0;
      out_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      oct_q       <= oct_d;
      note_q      <= note_d;
      out_index_q <= out_index_d;
      out_err_q   <= out_err_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_index = out_index_q;
  assign out_err   = out_err_q;
  assign out_valid = out_valid_q;
  assign dbg_state = state_q;

endmodule
